// File: rtl/tx_flit_scheduler_pkg.sv
// Shared types and constants for the TX flit scheduler.
package tx_flit_scheduler_pkg;

  localparam int FLIT_W   = 64;
  localparam int TX_AGE_W = 8;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    TX_SRC_NONE = 2'd0,
    TX_SRC_ACK  = 2'd1,
    TX_SRC_RETX = 2'd2,
    TX_SRC_FWD  = 2'd3
  } tx_src_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/tx_flit_scheduler_age.sv
// Anti-starvation age counter: counts consecutive cycles a source waits
// without being popped, saturating at AGE_LIMIT; urgent once saturated.
module tx_age_counter
  import tx_flit_scheduler_pkg::*;
#(
  parameter int AGE_LIMIT = 16
) (
  input  logic nocclk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic popped,
  output logic urgent
);

  localparam logic [TX_AGE_W-1:0] LIMIT = TX_AGE_W'(AGE_LIMIT);

  logic [TX_AGE_W-1:0] count_reg;

  // Count bypassed cycles; a pop or a dropped request restarts the wait.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (!req_valid || popped) begin
      count_reg <= '0;
    end else if (count_reg != LIMIT) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign urgent = (count_reg == LIMIT);

endmodule

// File: rtl/tx_flit_scheduler.sv
// Registered priority arbiter for the inter-device TX port.
// Sources: ack queue, retransmit buffer, forwarded queue. One-entry output
// register. Optional aging enabled by the macro TX_SCHED_AGING_EN.
module tx_flit_scheduler
  import tx_flit_scheduler_pkg::*;
#(
  parameter int AGE_LIMIT = 16
) (
  input  logic    nocclk,
  input  logic    rst_n,
  input  flit_t   ack_flit,
  input  logic    ack_flit_valid,
  output logic    ack_flit_ready,
  input  flit_t   retx_flit,
  input  logic    retx_flit_valid,
  output logic    retx_flit_ready,
  input  flit_t   fwd_flit,
  input  logic    fwd_flit_valid,
  output logic    fwd_flit_ready,
  output flit_t   flit_out,
  output logic    flit_out_valid,
  input  logic    flit_out_ready,
  output tx_src_t flit_out_src
);

  out_state_t state_reg;
  out_state_t state_next;
  tx_src_t    grant;
  flit_t      grant_flit;
  logic       load_en;
  logic       take;
  logic       drain;
  logic       retx_urgent;
  logic       fwd_urgent;

  assign load_en = (state_reg == ST_EMPTY) | (flit_out_valid & flit_out_ready);
  assign drain   = flit_out_valid & flit_out_ready;
  assign take    = load_en & (grant != TX_SRC_NONE);

`ifdef TX_SCHED_AGING_EN
  // Index 0 tracks retx, index 1 tracks fwd.
  logic [1:0] age_valid;
  logic [1:0] age_popped;
  logic [1:0] age_urgent;

  assign age_valid  = {fwd_flit_valid, retx_flit_valid};
  assign age_popped = {fwd_flit_valid & fwd_flit_ready,
                       retx_flit_valid & retx_flit_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_age
      tx_age_counter #(
        .AGE_LIMIT (AGE_LIMIT)
      ) u_age (
        .nocclk    (nocclk),
        .rst_n     (rst_n),
        .req_valid (age_valid[gi]),
        .popped    (age_popped[gi]),
        .urgent    (age_urgent[gi])
      );
    end
  endgenerate

  assign retx_urgent = age_urgent[0];
  assign fwd_urgent  = age_urgent[1];
`else
  // Aging compiled out: never true for a legal AGE_LIMIT, so strict priority.
  assign retx_urgent = (AGE_LIMIT == 0);
  assign fwd_urgent  = (AGE_LIMIT == 0);
`endif

  // Priority: urgent fwd > urgent retx > ack > retx > fwd.
  always_comb begin
    grant = TX_SRC_NONE;
    if (fwd_flit_valid && fwd_urgent) begin
      grant = TX_SRC_FWD;
    end else if (retx_flit_valid && retx_urgent) begin
      grant = TX_SRC_RETX;
    end else if (ack_flit_valid) begin
      grant = TX_SRC_ACK;
    end else if (retx_flit_valid) begin
      grant = TX_SRC_RETX;
    end else if (fwd_flit_valid) begin
      grant = TX_SRC_FWD;
    end
  end

  // One-hot ready to the granted source, only when the register can load.
  always_comb begin
    ack_flit_ready  = 1'b0;
    retx_flit_ready = 1'b0;
    fwd_flit_ready  = 1'b0;
    if (rst_n && load_en) begin
      case (grant)
        TX_SRC_ACK:  ack_flit_ready  = 1'b1;
        TX_SRC_RETX: retx_flit_ready = 1'b1;
        TX_SRC_FWD:  fwd_flit_ready  = 1'b1;
        default: ;
      endcase
    end
  end

  // Payload mux for the granted source.
  always_comb begin
    grant_flit = '0;
    case (grant)
      TX_SRC_ACK:  grant_flit = ack_flit;
      TX_SRC_RETX: grant_flit = retx_flit;
      TX_SRC_FWD:  grant_flit = fwd_flit;
      default: ;
    endcase
  end

  // Output register occupancy: fill on a pop, empty on a drain without refill.
  always_comb begin
    state_next = state_reg;
    if (take) begin
      state_next = ST_FULL;
    end else if (drain) begin
      state_next = ST_EMPTY;
    end
  end

  // Occupancy state register.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Held flit and its source tag; untouched while stalled.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      flit_out     <= '0;
      flit_out_src <= TX_SRC_NONE;
    end else if (take) begin
      flit_out     <= grant_flit;
      flit_out_src <= grant;
    end else if (drain) begin
      flit_out_src <= TX_SRC_NONE;
    end
  end

  assign flit_out_valid = (state_reg == ST_FULL);

endmodule

// File: tb/tb_tx_flit_scheduler.sv
// Self-checking bench for tx_flit_scheduler (AGE_LIMIT=4). Works with or
// without TX_SCHED_AGING_EN; the reference model follows the same macro.
module tb_tx_flit_scheduler;
  import tx_flit_scheduler_pkg::*;

  localparam int AGE = 4;
`ifdef TX_SCHED_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_ACK  = 2'd1;
  localparam logic [1:0] G_RETX = 2'd2;
  localparam logic [1:0] G_FWD  = 2'd3;

  logic    nocclk = 1'b0;
  logic    rst_n  = 1'b0;
  flit_t   ack_flit = '0, retx_flit = '0, fwd_flit = '0;
  logic    ack_flit_valid = 1'b0, retx_flit_valid = 1'b0, fwd_flit_valid = 1'b0;
  logic    ack_flit_ready, retx_flit_ready, fwd_flit_ready;
  flit_t   flit_out;
  logic    flit_out_valid;
  logic    flit_out_ready = 1'b0;
  tx_src_t flit_out_src;

  tx_flit_scheduler #(.AGE_LIMIT(AGE)) dut (
    .nocclk          (nocclk),
    .rst_n           (rst_n),
    .ack_flit        (ack_flit),
    .ack_flit_valid  (ack_flit_valid),
    .ack_flit_ready  (ack_flit_ready),
    .retx_flit       (retx_flit),
    .retx_flit_valid (retx_flit_valid),
    .retx_flit_ready (retx_flit_ready),
    .fwd_flit        (fwd_flit),
    .fwd_flit_valid  (fwd_flit_valid),
    .fwd_flit_ready  (fwd_flit_ready),
    .flit_out        (flit_out),
    .flit_out_valid  (flit_out_valid),
    .flit_out_ready  (flit_out_ready),
    .flit_out_src    (flit_out_src)
  );

  always #5 nocclk = ~nocclk;

  int checks   = 0;
  int failures = 0;
  int seq      = 0;

  // Reference model: output slot plus bypass counts per agable source.
  bit         m_valid;
  flit_t      m_flit;
  logic [1:0] m_src;
  int         w_retx, w_fwd;

  // Last cycle observations.
  logic [1:0] obs_grant;
  logic       post_valid;
  logic [1:0] post_src;
  flit_t      post_flit;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_grant();
    bit le;
    le = !m_valid || flit_out_ready;
    if (!le) return G_NONE;
    if (AGING && fwd_flit_valid && w_fwd >= AGE) return G_FWD;
    if (AGING && retx_flit_valid && w_retx >= AGE) return G_RETX;
    if (ack_flit_valid) return G_ACK;
    if (retx_flit_valid) return G_RETX;
    if (fwd_flit_valid) return G_FWD;
    return G_NONE;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_flit  = '0;
    m_src   = G_NONE;
    w_retx  = 0;
    w_fwd   = 0;
  endtask

  // Drive source valids and output ready with fresh, tagged payloads.
  task automatic drive(input bit a, input bit r, input bit f, input bit o);
    seq++;
    ack_flit        = {8'hAC, 24'h0, 32'(seq)};
    retx_flit       = {8'hE7, 24'h0, 32'(seq)};
    fwd_flit        = {8'hF0, 24'h0, 32'(seq)};
    ack_flit_valid  = a;
    retx_flit_valid = r;
    fwd_flit_valid  = f;
    flit_out_ready  = o;
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic do_cycle();
    logic [1:0] g;
    #1;
    g = model_grant();
    chk("ack_ready",  ack_flit_ready,  g == G_ACK);
    chk("retx_ready", retx_flit_ready, g == G_RETX);
    chk("fwd_ready",  fwd_flit_ready,  g == G_FWD);
    obs_grant = ack_flit_ready ? G_ACK : retx_flit_ready ? G_RETX :
                fwd_flit_ready ? G_FWD : G_NONE;
    @(posedge nocclk);
    if (g != G_NONE) begin
      m_valid = 1'b1;
      m_src   = g;
      m_flit  = (g == G_ACK) ? ack_flit : (g == G_RETX) ? retx_flit : fwd_flit;
    end else if (m_valid && flit_out_ready) begin
      m_valid = 1'b0;
      m_src   = G_NONE;
    end
    w_retx = (retx_flit_valid && g != G_RETX) ? ((w_retx < AGE) ? w_retx + 1 : AGE) : 0;
    w_fwd  = (fwd_flit_valid  && g != G_FWD)  ? ((w_fwd  < AGE) ? w_fwd  + 1 : AGE) : 0;
    #1;
    post_valid = flit_out_valid;
    post_src   = flit_out_src;
    post_flit  = flit_out;
    chk("out_valid", flit_out_valid, m_valid);
    chk("out_src",   flit_out_src,   m_src);
    if (m_valid) chk("out_flit", flit_out, m_flit);
    if (g != G_NONE) $display("pop src=%0d flit=%h", g, m_flit);
    @(negedge nocclk);
  endtask

  // Reset from a negedge with all sources requesting; readies must stay low.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 1);
    #1;
    model_reset();
    chk("rst_flit",  flit_out,        64'h0);
    chk("rst_valid", flit_out_valid,  1'b0);
    chk("rst_src",   flit_out_src,    G_NONE);
    chk("rst_ready", {ack_flit_ready, retx_flit_ready, fwd_flit_ready}, 3'b000);
    @(negedge nocclk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
  endtask

  typedef struct {
    bit         av, rv, fv, ordy;
    logic [1:0] exp_grant;
    logic       exp_valid;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs[10];
  flit_t fwd_q[$];
  flit_t a5_flit;

  initial begin
    vecs[0] = '{1,1,1,1, G_ACK,  1, G_ACK};
    vecs[1] = '{0,1,1,1, G_RETX, 1, G_RETX};
    vecs[2] = '{0,0,1,0, G_NONE, 1, G_RETX};
    vecs[3] = '{0,0,0,1, G_NONE, 0, G_NONE};
    vecs[4] = '{0,0,1,0, G_FWD,  1, G_FWD};
    vecs[5] = '{1,0,1,0, G_NONE, 1, G_FWD};
    vecs[6] = '{1,0,1,1, G_ACK,  1, G_ACK};
    vecs[7] = '{0,1,0,1, G_RETX, 1, G_RETX};
    vecs[8] = '{0,0,0,0, G_NONE, 1, G_RETX};
    vecs[9] = '{0,0,0,1, G_NONE, 0, G_NONE};

    model_reset();
    @(negedge nocclk);
    do_reset();

    // Table-driven single-cycle vectors from an empty register.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].av, vecs[i].rv, vecs[i].fv, vecs[i].ordy);
      do_cycle();
      chk($sformatf("vec%0d_grant", i), obs_grant,  vecs[i].exp_grant);
      chk($sformatf("vec%0d_valid", i), post_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_src", i),   post_src,   vecs[i].exp_src);
    end

    // Strict priority: ack wins while present, then retx takes over.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1);
      do_cycle();
      chk("prio_ack", obs_grant, G_ACK);
    end
    drive(0, 1, 1, 1);
    do_cycle();
    chk("prio_retx", obs_grant, G_RETX);

    // Backpressure: held flit is stable, no readies, then zero-bubble refill.
    do_reset();
    drive(1, 0, 0, 1);
    a5_flit  = 64'hA5A5_A5A5_A5A5_A5A5;
    ack_flit = a5_flit;
    do_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0);
      do_cycle();
      chk("bp_hold_flit", post_flit,  a5_flit);
      chk("bp_hold_vld",  post_valid, 1'b1);
      chk("bp_no_ready",  obs_grant,  G_NONE);
    end
    drive(1, 0, 0, 1);
    do_cycle();
    chk("bp_resume_grant", obs_grant,  G_ACK);
    chk("bp_resume_vld",   post_valid, 1'b1);
    chk("bp_resume_flit",  post_flit,  ack_flit);

    // Aging: ack and fwd always valid -> fwd every 5th pop when aging is on.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 1, 1);
      do_cycle();
      chk($sformatf("age_pop%0d", i), obs_grant, (AGING && (i % 5 == 4)) ? G_FWD : G_ACK);
      chk($sformatf("age_src%0d", i), post_src,  (AGING && (i % 5 == 4)) ? G_FWD : G_ACK);
    end

    // Retx versus fwd without ack.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 1, 1);
      do_cycle();
      chk($sformatf("rf_pop%0d", i), obs_grant, (AGING && (i % 5 == 4)) ? G_FWD : G_RETX);
    end

    // Throughput and latency: 8 back-to-back fwd flits, order preserved.
    do_reset();
    fwd_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        drive(0, 0, 1, 1);
        fwd_q.push_back(fwd_flit);
      end else begin
        drive(0, 0, 0, 1);
      end
      do_cycle();
      chk($sformatf("tp_vld%0d", i), post_valid, i < 8);
      if (i < 8) chk($sformatf("tp_flit%0d", i), post_flit, fwd_q[i]);
    end

    // Reset mid-hold: asserted between edges, takes effect at once.
    do_reset();
    drive(1, 0, 0, 1);
    do_cycle();
    drive(1, 1, 1, 0);
    do_cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", flit_out_valid, 1'b0);
    chk("mid_rst_src",   flit_out_src,   G_NONE);
    chk("mid_rst_ready", {ack_flit_ready, retx_flit_ready, fwd_flit_ready}, 3'b000);
    model_reset();
    @(negedge nocclk);
    rst_n = 1'b1;
    drive(1, 1, 1, 1);
    do_cycle();
    chk("post_rst_grant", obs_grant, G_ACK);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
